// File: rtl/register_file_scoreboard_unit_if.sv
// Bundle of the register-file ports: write/writeback port, two source read
// ports, destination reservation and the busy counter.
interface register_file_scoreboard_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] write_data;

   logic [ADDR_WIDTH-1:0] read_address0;
   logic [ADDR_WIDTH-1:0] read_address1;
   logic [DATA_WIDTH-1:0] read_data0;
   logic [DATA_WIDTH-1:0] read_data1;
   logic                  read_busy0;
   logic                  read_busy1;

   logic                  reserve_enable;
   logic [ADDR_WIDTH-1:0] reserve_address;
   logic                  reserve_accept;

   logic [ADDR_WIDTH:0]   busy_count;

   // Issue/writeback side drives requests; the register file answers.
   modport master (
      output write_enable, write_address, write_data,
      output read_address0, read_address1,
      output reserve_enable, reserve_address,
      input  read_data0, read_data1, read_busy0, read_busy1,
      input  reserve_accept, busy_count
   );

   modport slave (
      input  write_enable, write_address, write_data,
      input  read_address0, read_address1,
      input  reserve_enable, reserve_address,
      output read_data0, read_data1, read_busy0, read_busy1,
      output reserve_accept, busy_count
   );
endinterface

// File: rtl/register_file_scoreboard_unit.sv
// Register file with two combinational read ports (write bypass), one write
// port and a per-register busy scoreboard. Option macro: REGFILE_ZERO_REG_EN.
module register_file_scoreboard_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic                            clock,
   input logic                            reset,
   register_file_scoreboard_unit_if.slave rf
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
   localparam logic ZERO_REG = 1'b1;
`else
   localparam logic ZERO_REG = 1'b0;
`endif

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH:0]   count_t;

   data_t            regs_q [DEPTH];
   data_t            regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   count_t           busy_count_q;
   count_t           busy_count_d;

   logic zero_read0;
   logic zero_read1;
   logic zero_write;
   logic zero_reserve;
   logic read_bypass0;
   logic read_bypass1;
   logic write_fire;
   logic reserve_hits_write;
   logic reserve_sets;
   logic count_inc;
   logic count_dec;

   // Address-0 qualifiers fold to constant 0 when r0 is an ordinary register.
   assign zero_read0   = ZERO_REG && (rf.read_address0 == '0);
   assign zero_read1   = ZERO_REG && (rf.read_address1 == '0);
   assign zero_write   = ZERO_REG && (rf.write_address == '0);
   assign zero_reserve = ZERO_REG && (rf.reserve_address == '0);

   assign read_bypass0 = rf.write_enable && (rf.write_address == rf.read_address0);
   assign read_bypass1 = rf.write_enable && (rf.write_address == rf.read_address1);

   // NOTE: combinational blocks use blocking '=' with a default for every
   // output first, so no latch is inferred; flops below use '<=' only.
   always_comb begin
      rf.read_data0 = regs_q[rf.read_address0];
      rf.read_busy0 = busy_q[rf.read_address0];
      if (zero_read0) begin
         rf.read_data0 = '0;
         rf.read_busy0 = 1'b0;
      end else if (read_bypass0) begin
         rf.read_data0 = rf.write_data;
         rf.read_busy0 = 1'b0;
      end
   end

   always_comb begin
      rf.read_data1 = regs_q[rf.read_address1];
      rf.read_busy1 = busy_q[rf.read_address1];
      if (zero_read1) begin
         rf.read_data1 = '0;
         rf.read_busy1 = 1'b0;
      end else if (read_bypass1) begin
         rf.read_data1 = rf.write_data;
         rf.read_busy1 = 1'b0;
      end
   end

   // A busy destination is still grantable when its writeback lands this cycle.
   assign write_fire         = rf.write_enable && !zero_write;
   assign reserve_hits_write = rf.write_enable && (rf.write_address == rf.reserve_address);
   assign rf.reserve_accept  = rf.reserve_enable &&
                               (zero_reserve || !busy_q[rf.reserve_address] || reserve_hits_write);
   assign reserve_sets       = rf.reserve_accept && !zero_reserve;

   assign count_inc = reserve_sets && !busy_q[rf.reserve_address];
   assign count_dec = write_fire && busy_q[rf.write_address] &&
                      !(reserve_sets && (rf.reserve_address == rf.write_address));

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (write_fire) begin
         regs_d[rf.write_address] = rf.write_data;
         busy_d[rf.write_address] = 1'b0;
      end
      // Applied after the write so a same-address reservation wins.
      if (reserve_sets) begin
         busy_d[rf.reserve_address] = 1'b1;
      end
   end

   always_comb begin
      busy_count_d = busy_count_q;
      case ({count_inc, count_dec})
         2'b10:   busy_count_d = busy_count_q + count_t'(1);
         2'b01:   busy_count_d = busy_count_q - count_t'(1);
         default: busy_count_d = busy_count_q;
      endcase
   end

   assign rf.busy_count = busy_count_q;

   // NOTE: the storage array is reset along with the scoreboard because reads
   // after reset must return zero; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end
endmodule

// File: tb/tb_register_file_scoreboard_unit.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle, a
// negedge monitor pops and compares them against the DUT.
module tb_register_file_scoreboard_unit;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2 ** AW;
`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] rd0;
      logic [DW-1:0] rd1;
      logic          rb0;
      logic          rb1;
      logic          acc;
      logic [AW:0]   cnt;
   } exp_t;

   logic clock;
   logic reset;
   register_file_scoreboard_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

   register_file_scoreboard_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock),
      .reset(reset),
      .rf   (rf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   // Reference model: plain arrays of register values and busy flags.
   logic [DW-1:0] m_regs [DEPTH];
   bit            m_busy [DEPTH];

   task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic logic [DW-1:0] model_data(input int a, input bit we, input int wa, input logic [DW-1:0] wd);
      if (ZR && a == 0) return '0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   function automatic bit model_busy(input int a, input bit we, input int wa);
      if (ZR && a == 0) return 1'b0;
      if (we && wa == a) return 1'b0;
      return m_busy[a];
   endfunction

   // One clock cycle of stimulus; rst_v is the level of reset for this cycle.
   task automatic cycle(input bit rst_v, input bit we, input int wa, input logic [DW-1:0] wd,
                        input int a0, input int a1, input bit re, input int ra);
      exp_t e;
      bit   acc;
      @(posedge clock);
      #1;
      reset                = rst_v;
      rf.write_enable      = we;
      rf.write_address     = AW'(wa);
      rf.write_data        = wd;
      rf.read_address0     = AW'(a0);
      rf.read_address1     = AW'(a1);
      rf.reserve_enable    = re;
      rf.reserve_address   = AW'(ra);
      if (!rst_v) model_clear();
      acc   = re && ((ZR && ra == 0) || !m_busy[ra] || (we && wa == ra));
      e.rd0 = model_data(a0, we, wa, wd);
      e.rd1 = model_data(a1, we, wa, wd);
      e.rb0 = model_busy(a0, we, wa);
      e.rb1 = model_busy(a1, we, wa);
      e.acc = acc;
      e.cnt = (AW + 1)'(model_count());
      exp_q.push_back(e);
      if (rst_v) begin
         if (we && !(ZR && wa == 0)) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
         end
         if (acc && !(ZR && ra == 0)) m_busy[ra] = 1'b1;
      end
   endtask

   task automatic idle(input int a0, input int a1);
      cycle(1'b1, 1'b0, 0, '0, a0, a1, 1'b0, 0);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("read_data0", rf.read_data0, e.rd0);
         check("read_data1", rf.read_data1, e.rd1);
         check("read_busy0", DW'(rf.read_busy0), DW'(e.rb0));
         check("read_busy1", DW'(rf.read_busy1), DW'(e.rb1));
         check("reserve_accept", DW'(rf.reserve_accept), DW'(e.acc));
         check("busy_count", DW'(rf.busy_count), DW'(e.cnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset              = 1'b0;
      rf.write_enable    = 1'b0;
      rf.write_address   = '0;
      rf.write_data      = '0;
      rf.read_address0   = '0;
      rf.read_address1   = '0;
      rf.reserve_enable  = 1'b0;
      rf.reserve_address = '0;
      model_clear();

      // Reset state, then reads of r3/r7.
      cycle(1'b0, 1'b0, 0, '0, 3, 7, 1'b0, 0);
      idle(3, 7);
      // Write r5 with same-cycle read (bypass), then read through storage.
      cycle(1'b1, 1'b1, 5, 32'hDEADBEEF, 5, 6, 1'b0, 0);
      idle(5, 5);
      // Reserve r9 twice, then write it back.
      cycle(1'b1, 1'b0, 0, '0, 9, 9, 1'b1, 9);
      cycle(1'b1, 1'b0, 0, '0, 9, 9, 1'b1, 9);
      cycle(1'b1, 1'b1, 9, 32'h12, 9, 1, 1'b0, 0);
      idle(9, 9);
      // r4 busy, then write+reserve r4 in the same cycle.
      cycle(1'b1, 1'b0, 0, '0, 4, 4, 1'b1, 4);
      cycle(1'b1, 1'b1, 4, 32'hCAFE0004, 4, 5, 1'b1, 4);
      idle(4, 4);
      cycle(1'b1, 1'b1, 4, 32'h44, 4, 4, 1'b0, 0);
      // Reservations interrupted by reset.
      cycle(1'b1, 1'b1, 2, 32'h2222, 2, 3, 1'b1, 2);
      cycle(1'b1, 1'b0, 0, '0, 2, 3, 1'b1, 3);
      cycle(1'b1, 1'b0, 0, '0, 2, 4, 1'b1, 4);
      cycle(1'b0, 1'b0, 0, '0, 2, 4, 1'b1, 7);
      idle(2, 3);
      // Register 0 writes and reservation.
      cycle(1'b1, 1'b1, 0, 32'h55, 0, 1, 1'b0, 0);
      idle(0, 0);
      cycle(1'b1, 1'b0, 0, '0, 0, 2, 1'b1, 0);
      idle(0, 0);
      cycle(1'b1, 1'b1, 0, 32'h77, 0, 0, 1'b1, 0);
      idle(0, 0);

      // Randomized traffic, half of it on a narrow address window for hazards.
      for (int n = 0; n < 1500; n++) begin
         int  hi;
         bit  rst_v;
         hi    = ($urandom_range(0, 1) == 1) ? 7 : DEPTH - 1;
         rst_v = ($urandom_range(0, 199) != 0);
         cycle(rst_v, $urandom_range(0, 1) == 1, int'($urandom_range(0, hi)), $urandom,
               int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
               $urandom_range(0, 2) != 0, int'($urandom_range(0, hi)));
      end
      // Fill every register busy to exercise the upper count bound.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0, '0, i, 0, 1'b1, i);
      idle(1, 2);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, i, DW'(i * 3), i, 0, 1'b0, 0);
      idle(1, 2);

      @(negedge clock);
      #1;
      check("scoreboard_drained", DW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
